// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg : shared write-back encodings for the MIPS32 core
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_BU = 3'd1,
        LD_H  = 3'd2,
        LD_HU = 3'd3,
        LD_W  = 3'd4
    } ld_type_e;

    localparam int REG_ZERO = 0;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
//------------------------------------------------------------------------------
// load_extend : selects and sign/zero-extends the loaded byte, half or word
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_extend
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_mem,
    input  logic [2:0]        i_ld_type,
    input  logic [1:0]        i_addr_lo,
    output logic [DATA_W-1:0] o_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane select: byte k lives at bits [8k+7:8k].
    assign w_byte = i_mem[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_mem[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_word = i_mem;
        case (i_ld_type)
            LD_B:    o_word = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_BU:   o_word = {{(DATA_W-8){1'b0}}, w_byte};
            LD_H:    o_word = {{(DATA_W-16){w_half[15]}}, w_half};
            LD_HU:   o_word = {{(DATA_W-16){1'b0}}, w_half};
            default: o_word = i_mem;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
//------------------------------------------------------------------------------
// writeback_stage : MEM/WB pipeline register, write-back mux and forwarding tap
// Revision        : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module writeback_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_regwrite,
    input  logic [REG_W-1:0]  in_dest,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_ld_type,
    input  logic [1:0]        in_addr_lo,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_pc4,
    output logic [REG_W-1:0]  WriteRegister,
    output logic [DATA_W-1:0] WriteData_reg,
    output logic              RegWrite,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_count
);

    logic              r_wb_valid;
    logic              r_wb_regwrite;
    logic [REG_W-1:0]  r_wb_dest;
    logic [1:0]        r_wb_sel;
    logic [2:0]        r_wb_ld_type;
    logic [1:0]        r_wb_addr_lo;
    logic [DATA_W-1:0] r_wb_alu;
    logic [DATA_W-1:0] r_wb_mem;
    logic [DATA_W-1:0] r_wb_pc4;
    logic              r_written;
    logic [CNT_W-1:0]  r_retire;

    logic              w_writes_gpr;
    logic              w_regwrite;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_wdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_dest     <= '0;
            r_wb_sel      <= '0;
            r_wb_ld_type  <= '0;
            r_wb_addr_lo  <= '0;
            r_wb_alu      <= '0;
            r_wb_mem      <= '0;
            r_wb_pc4      <= '0;
            r_written     <= 1'b0;
        end else if (!stall) begin
            r_wb_valid    <= in_valid & ~flush;
            r_wb_regwrite <= in_regwrite;
            r_wb_dest     <= in_dest;
            r_wb_sel      <= in_wb_sel;
            r_wb_ld_type  <= in_ld_type;
            r_wb_addr_lo  <= in_addr_lo;
            r_wb_alu      <= in_alu;
            r_wb_mem      <= in_mem;
            r_wb_pc4      <= in_pc4;
            r_written     <= 1'b0;
        end else if (w_regwrite) begin
            // The register file has taken the write; suppress repeats while held.
            r_written     <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retire <= '0;
        end else if (r_wb_valid && !stall) begin
            r_retire <= r_retire + CNT_W'(1);
        end
    end

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .i_mem     (r_wb_mem),
        .i_ld_type (r_wb_ld_type),
        .i_addr_lo (r_wb_addr_lo),
        .o_word    (w_load)
    );

    assign w_writes_gpr = r_wb_valid & r_wb_regwrite & (r_wb_dest != REG_W'(REG_ZERO));
    assign w_regwrite   = w_writes_gpr & ~r_written;

    always_comb begin
        w_wdata = r_wb_alu;
        case (r_wb_sel)
            WB_SEL_MEM:  w_wdata = w_load;
            WB_SEL_LINK: w_wdata = r_wb_pc4;
            default:     w_wdata = r_wb_alu;
        endcase
    end

    assign WriteRegister = r_wb_dest;
    assign WriteData_reg = w_wdata;
    assign RegWrite      = w_regwrite;
    // Forwarding ignores the written flag so dependants still see the value while stalled.
    assign fwd_valid     = w_writes_gpr;
    assign fwd_reg       = r_wb_dest;
    assign fwd_data      = w_wdata;
    assign retire_count  = r_retire;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
//------------------------------------------------------------------------------
// tb_writeback_stage : directed self-checking bench for writeback_stage
// Revision           : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_writeback_stage;
    import mips_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_regwrite = 1'b0;
    logic [4:0]  in_dest = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [2:0]  in_ld_type = '0;
    logic [1:0]  in_addr_lo = '0;
    logic [31:0] in_alu = '0;
    logic [31:0] in_mem = '0;
    logic [31:0] in_pc4 = '0;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData_reg;
    logic        RegWrite;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic [31:0] retire_count;

    int n_asserts = 0;
    int n_fail    = 0;

    writeback_stage #(
        .DATA_W (32),
        .REG_W  (5),
        .CNT_W  (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_regwrite   (in_regwrite),
        .in_dest       (in_dest),
        .in_wb_sel     (in_wb_sel),
        .in_ld_type    (in_ld_type),
        .in_addr_lo    (in_addr_lo),
        .in_alu        (in_alu),
        .in_mem        (in_mem),
        .in_pc4        (in_pc4),
        .WriteRegister (WriteRegister),
        .WriteData_reg (WriteData_reg),
        .RegWrite      (RegWrite),
        .fwd_valid     (fwd_valid),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data),
        .retire_count  (retire_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] d,
                         input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] lo,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
        in_valid    = v;
        in_regwrite = rw;
        in_dest     = d;
        in_wb_sel   = sel;
        in_ld_type  = lt;
        in_addr_lo  = lo;
        in_alu      = alu;
        in_mem      = mem;
        in_pc4      = pc4;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, WB_SEL_ALU, LD_W, 2'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic chk_out(input string tag, input logic rw, input logic fv,
                           input logic [4:0] wr, input logic [31:0] wd, input logic [31:0] rc);
        chk({tag, ".RegWrite"},      {31'd0, RegWrite},      {31'd0, rw});
        chk({tag, ".fwd_valid"},     {31'd0, fwd_valid},     {31'd0, fv});
        chk({tag, ".WriteRegister"}, {27'd0, WriteRegister}, {27'd0, wr});
        chk({tag, ".WriteData_reg"}, WriteData_reg,          wd);
        chk({tag, ".fwd_reg"},       {27'd0, fwd_reg},       {27'd0, wr});
        chk({tag, ".fwd_data"},      fwd_data,               wd);
        chk({tag, ".retire_count"},  retire_count,           rc);
    endtask

    initial begin
        // Reset with garbage on the inputs, then release mid-cycle.
        drive(1'b1, 1'b1, 5'd9, WB_SEL_ALU, LD_W, 2'd0, 32'hDEAD, 32'h0, 32'h0);
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        idle();
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk_out("post_reset", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

        // ALU write, single-cycle pulse
        drive(1'b1, 1'b1, 5'd9, WB_SEL_ALU, LD_W, 2'd0, 32'h1234, 32'h5555, 32'h8);
        tick();
        chk_out("alu", 1'b1, 1'b1, 5'd9, 32'h1234, 32'd0);
        idle();
        tick();
        chk_out("alu_after", 1'b0, 1'b0, 5'd0, 32'h0, 32'd1);

        // Load extension variants on 0x80FF7F01
        drive(1'b1, 1'b1, 5'd5, WB_SEL_MEM, LD_B, 2'd3, 32'h1111, 32'h80FF7F01, 32'h0);
        tick();
        chk_out("lb3", 1'b1, 1'b1, 5'd5, 32'hFFFFFF80, 32'd1);
        drive(1'b1, 1'b1, 5'd6, WB_SEL_MEM, LD_BU, 2'd2, 32'h1111, 32'h80FF7F01, 32'h0);
        tick();
        chk_out("lbu2", 1'b1, 1'b1, 5'd6, 32'h000000FF, 32'd2);
        drive(1'b1, 1'b1, 5'd7, WB_SEL_MEM, LD_H, 2'd2, 32'h1111, 32'h80FF7F01, 32'h0);
        tick();
        chk_out("lh2", 1'b1, 1'b1, 5'd7, 32'hFFFF80FF, 32'd3);
        drive(1'b1, 1'b1, 5'd8, WB_SEL_MEM, LD_HU, 2'd0, 32'h1111, 32'h80FF7F01, 32'h0);
        tick();
        chk_out("lhu0", 1'b1, 1'b1, 5'd8, 32'h00007F01, 32'd4);
        drive(1'b1, 1'b1, 5'd10, WB_SEL_MEM, LD_B, 2'd0, 32'h1111, 32'h80FF7F01, 32'h0);
        tick();
        chk_out("lb0", 1'b1, 1'b1, 5'd10, 32'h00000001, 32'd5);
        drive(1'b1, 1'b1, 5'd11, WB_SEL_MEM, LD_W, 2'd3, 32'h1111, 32'h80FF7F01, 32'h0);
        tick();
        chk_out("lw", 1'b1, 1'b1, 5'd11, 32'h80FF7F01, 32'd6);

        // Write to $0 is suppressed but still retires; wb_sel=11 behaves as ALU
        drive(1'b1, 1'b1, 5'd0, 2'b11, LD_W, 2'd0, 32'hCAFE, 32'h0, 32'h0);
        tick();
        chk_out("dest0", 1'b0, 1'b0, 5'd0, 32'hCAFE, 32'd7);
        idle();
        tick();
        chk_out("dest0_after", 1'b0, 1'b0, 5'd0, 32'h0, 32'd8);

        // Stall for 3 cycles on a write to $17
        drive(1'b1, 1'b1, 5'd17, WB_SEL_ALU, LD_W, 2'd0, 32'hABCD, 32'h0, 32'h0);
        tick();
        chk_out("stall_c1", 1'b1, 1'b1, 5'd17, 32'hABCD, 32'd8);
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd3, WB_SEL_ALU, LD_W, 2'd0, 32'h7777, 32'h0, 32'h0);
        tick();
        chk_out("stall_c2", 1'b0, 1'b1, 5'd17, 32'hABCD, 32'd8);
        flush = 1'b1;
        tick();
        chk_out("stall_c3", 1'b0, 1'b1, 5'd17, 32'hABCD, 32'd8);
        stall = 1'b0;
        flush = 1'b0;
        idle();
        tick();
        chk_out("stall_rel", 1'b0, 1'b0, 5'd0, 32'h0, 32'd9);

        // Flush discards the incoming instruction
        flush = 1'b1;
        drive(1'b1, 1'b1, 5'd4, WB_SEL_ALU, LD_W, 2'd0, 32'h4444, 32'h0, 32'h0);
        tick();
        chk_out("flush", 1'b0, 1'b0, 5'd4, 32'h4444, 32'd9);
        flush = 1'b0;

        // JAL link write to $31
        drive(1'b1, 1'b1, 5'd31, WB_SEL_LINK, LD_W, 2'd0, 32'h9999, 32'h0, 32'h40);
        tick();
        chk_out("jal", 1'b1, 1'b1, 5'd31, 32'h40, 32'd9);
        idle();
        tick();
        chk_out("jal_after", 1'b0, 1'b0, 5'd0, 32'h0, 32'd10);

        // Asynchronous reset in the middle of a stall drops the held instruction
        drive(1'b1, 1'b1, 5'd12, WB_SEL_ALU, LD_W, 2'd0, 32'h1212, 32'h0, 32'h0);
        tick();
        stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst_stall", 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);
        stall = 1'b0;
        idle();
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk_out("rst_stall_after", 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
